// File: rtl/speed_pkg.sv
// Shared constants and types for the game-speed tick generator.
// Optional auto speed-up ramp is enabled by defining SPEED_AUTO_RAMP_EN.
package speed_pkg;

  localparam int SPD_CLK_HZ     = 50000000;
  localparam int SPD_BASE_DIV   = 25000000;
  localparam int SPD_NUM_LEVELS = 4;

  typedef logic [1:0] speed_lvl_t;

  // Width of a level index; never narrower than one bit.
  function automatic int lvl_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/speed_level_ctrl.sv
// Current speed level register with load/step commands, saturation and clamping.
// With SPEED_AUTO_RAMP_EN defined, a per-level tick counter issues automatic speed-ups.
module speed_level_ctrl
  import speed_pkg::*;
#(
  parameter int NUM_LEVELS = SPD_NUM_LEVELS,
`ifdef SPEED_AUTO_RAMP_EN
  parameter int RAMP_TICKS = 8,
`endif
  localparam int LVL_W = lvl_width(NUM_LEVELS)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             level_load,
  input  logic [LVL_W-1:0] level_in,
  input  logic             speed_up,
  input  logic             slow_down,
`ifdef SPEED_AUTO_RAMP_EN
  input  logic             auto_ramp,
  input  logic             tick_evt,
`endif
  output logic [LVL_W-1:0] cur_level,
  output logic [LVL_W-1:0] level_nxt,
  output logic             level_changed
);

  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(NUM_LEVELS - 1);

  function automatic logic [LVL_W-1:0] sat_inc(input logic [LVL_W-1:0] l);
    return (l == MAX_LVL) ? l : l + LVL_W'(1);
  endfunction

  function automatic logic [LVL_W-1:0] sat_dec(input logic [LVL_W-1:0] l);
    return (l == '0) ? l : l - LVL_W'(1);
  endfunction

  // Out-of-range loads land on the fastest legal level.
  function automatic logic [LVL_W-1:0] clamp_level(input logic [LVL_W-1:0] l);
    return ({1'b0, l} > {1'b0, MAX_LVL}) ? MAX_LVL : l;
  endfunction

`ifdef SPEED_AUTO_RAMP_EN
  localparam int RAMP_W = $clog2(RAMP_TICKS + 1);

  logic [RAMP_W-1:0] ramp_cnt;
  logic              ramp_req;

  // Request stays pending until a level change consumes it or the level saturates.
  assign ramp_req = auto_ramp && (ramp_cnt == RAMP_W'(RAMP_TICKS));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ramp_cnt <= '0;
    end else if (level_changed) begin
      ramp_cnt <= '0;
    end else if (auto_ramp && tick_evt && (ramp_cnt != RAMP_W'(RAMP_TICKS))) begin
      ramp_cnt <= ramp_cnt + RAMP_W'(1);
    end
  end
`endif

  // Load beats stepping; opposing steps cancel; the ramp only acts when the bus is idle.
  always_comb begin
    level_nxt = cur_level;
    if (level_load) begin
      level_nxt = clamp_level(level_in);
    end else if (speed_up && !slow_down) begin
      level_nxt = sat_inc(cur_level);
    end else if (slow_down && !speed_up) begin
      level_nxt = sat_dec(cur_level);
    end
`ifdef SPEED_AUTO_RAMP_EN
    else if (!speed_up && !slow_down && ramp_req) begin
      level_nxt = sat_inc(cur_level);
    end
`endif
  end

  assign level_changed = (level_nxt != cur_level);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cur_level <= '0;
    end else begin
      cur_level <= level_nxt;
    end
  end

endmodule

// File: rtl/speed_tick_gen.sv
// Game-speed tick generator: one tick every BASE_DIV >> level cycles, with pause and tick count.
// Define SPEED_AUTO_RAMP_EN to add the AutoRamp port and automatic per-level speed-up.
module speed_tick_gen
  import speed_pkg::*;
#(
  parameter int BASE_DIV   = SPD_BASE_DIV,
  parameter int NUM_LEVELS = SPD_NUM_LEVELS,
  parameter int CNT_W      = 26,
`ifdef SPEED_AUTO_RAMP_EN
  parameter int RAMP_TICKS = 8,
`endif
  localparam int LVL_W = lvl_width(NUM_LEVELS)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Enable,
  input  logic             LevelLoad,
  input  logic [LVL_W-1:0] Level,
  input  logic             SpeedUp,
  input  logic             SlowDown,
`ifdef SPEED_AUTO_RAMP_EN
  input  logic             AutoRamp,
`endif
  output logic             Tick,
  output logic [LVL_W-1:0] CurLevel,
  output logic [15:0]      TickCount
);

  function automatic logic [CNT_W-1:0] period_last(input logic [LVL_W-1:0] lvl);
    int p;
    p = BASE_DIV >> lvl;
    return CNT_W'(p - 1);
  endfunction

  logic [LVL_W-1:0] level_nxt;
  logic             level_changed;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] term_cnt;
  logic             period_wrap;

  speed_level_ctrl #(
    .NUM_LEVELS (NUM_LEVELS)
`ifdef SPEED_AUTO_RAMP_EN
    , .RAMP_TICKS (RAMP_TICKS)
`endif
  ) u_level_ctrl (
    .Clock         (Clock),
    .Resetn        (Resetn),
    .level_load    (LevelLoad),
    .level_in      (Level),
    .speed_up      (SpeedUp),
    .slow_down     (SlowDown),
`ifdef SPEED_AUTO_RAMP_EN
    .auto_ramp     (AutoRamp),
    .tick_evt      (period_wrap),
`endif
    .cur_level     (CurLevel),
    .level_nxt     (level_nxt),
    .level_changed (level_changed)
  );

  // A level change always restarts the period, so no partial-period tick escapes.
  assign period_wrap = Enable && !level_changed && (count == term_cnt);

  // Terminal count is registered from the next level, keeping the shifter out of the compare path.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count     <= '0;
      term_cnt  <= period_last('0);
      Tick      <= 1'b0;
      TickCount <= '0;
    end else begin
      term_cnt <= period_last(level_nxt);
      Tick     <= period_wrap;
      if (level_changed || period_wrap) begin
        count <= '0;
      end else if (Enable) begin
        count <= count + CNT_W'(1);
      end
      if (period_wrap) begin
        TickCount <= TickCount + 16'd1;
      end
    end
  end

endmodule
